// File: rtl/fmdll_sel_ctrl.sv
// Sequencer for the FMDLL delay-line input mux: counts loop edges (N) and injections (M),
// drives a registered one-hot mux select, flags early/late reference edges and reports lock.
module fmdll_sel_ctrl #(
    parameter int N_W    = 4,
    parameter int M_W    = 2,
    parameter int TO_W   = 8,
    parameter int LOCK_N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           ring_edge,
    input  logic           ext_edge,
    input  logic [N_W-1:0] n_div,
    input  logic [M_W-1:0] m_div,
    output logic [1:0]     sel,
    output logic [N_W-1:0] n_cnt,
    output logic [M_W-1:0] m_cnt,
    output logic           err_early,
    output logic           err_late,
    output logic           locked,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INJECT = 3'd1,
        S_RECIRC = 3'd2,
        S_ARM    = 3'd3,
        S_CAL    = 3'd4
    } state_t;

    localparam logic [1:0]      SEL_RECIRC = 2'b00;
    localparam logic [1:0]      SEL_INJECT = 2'b10;
    localparam logic [1:0]      SEL_CAL    = 2'b01;
    // Value one step short of all-ones: the increment onto all-ones is the timeout event.
    localparam logic [TO_W-1:0] TO_PRE     = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]      LOCK_MAX   = 4'(LOCK_N);

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [N_W-1:0]  n_cnt_q, n_cnt_d;
    logic [M_W-1:0]  m_cnt_q, m_cnt_d;
    logic [N_W-1:0]  n_sh_q, n_sh_d;
    logic [M_W-1:0]  m_sh_q, m_sh_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      lock_cnt_q, lock_cnt_d;
    logic            locked_q, locked_d;
    logic            err_early_q, err_early_d;
    logic            err_late_q, err_late_d;
    logic            on_time;
    logic            terminal;

    assign terminal = ring_edge && (n_cnt_q == (n_sh_q - N_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= SEL_RECIRC;
            n_cnt_q     <= '0;
            m_cnt_q     <= '0;
            n_sh_q      <= '0;
            m_sh_q      <= '0;
            to_cnt_q    <= '0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            n_cnt_q     <= n_cnt_d;
            m_cnt_q     <= m_cnt_d;
            n_sh_q      <= n_sh_d;
            m_sh_q      <= m_sh_d;
            to_cnt_q    <= to_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_cnt_d     = n_cnt_q;
        m_cnt_d     = m_cnt_q;
        n_sh_d      = n_sh_q;
        m_sh_d      = m_sh_q;
        to_cnt_d    = to_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        on_time     = 1'b0;
        sel_d       = SEL_RECIRC;

        if (!en) begin
            state_d    = S_IDLE;
            n_cnt_d    = '0;
            m_cnt_d    = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ext_edge) state_d = S_INJECT;
                end
                S_INJECT: begin
                    n_sh_d  = (n_div == '0) ? N_W'(1) : n_div;
                    m_sh_d  = m_div;
                    n_cnt_d = '0;
                    state_d = S_RECIRC;
                end
                S_RECIRC: begin
                    if (terminal) begin
                        n_cnt_d = '0;
                        if (ext_edge) begin
                            on_time = 1'b1;
                        end else begin
                            state_d  = S_ARM;
                            to_cnt_d = '0;
                        end
                    end else if (ext_edge) begin
                        // Reference arrived before N loop edges: resync by re-injecting.
                        err_early_d = 1'b1;
                        lock_cnt_d  = '0;
                        locked_d    = 1'b0;
                        n_cnt_d     = '0;
                        state_d     = S_INJECT;
                    end else if (ring_edge) begin
                        n_cnt_d = n_cnt_q + N_W'(1);
                    end
                end
                S_ARM: begin
                    if (ext_edge) begin
                        on_time = 1'b1;
                    end else if (to_cnt_q == TO_PRE) begin
                        err_late_d = 1'b1;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        to_cnt_d   = '1;
                        state_d    = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_CAL: begin
                    if (ext_edge) state_d = S_INJECT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (on_time) begin
                if (lock_cnt_q < LOCK_MAX) lock_cnt_d = lock_cnt_q + 4'd1;
                if (lock_cnt_d >= LOCK_MAX) locked_d = 1'b1;
                if (m_cnt_q == m_sh_q) begin
                    m_cnt_d = '0;
                    state_d = S_CAL;
                end else begin
                    m_cnt_d = m_cnt_q + M_W'(1);
                    state_d = S_INJECT;
                end
            end
        end

        // Select is decoded from the next state so the mux sees a registered one-hot code.
        case (state_d)
            S_INJECT: sel_d = SEL_INJECT;
            S_CAL:    sel_d = SEL_CAL;
            default:  sel_d = SEL_RECIRC;
        endcase
    end

    assign sel       = sel_q;
    assign n_cnt     = n_cnt_q;
    assign m_cnt     = m_cnt_q;
    assign err_early = err_early_q;
    assign err_late  = err_late_q;
    assign locked    = locked_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fmdll_sel_ctrl.sv
// Directed bench for fmdll_sel_ctrl: inject/recirc/calibrate sequencing, early and late
// reference edges, lock build-up and loss, and n_div=0 handling (TO_W=3 for a short timeout).
module tb_fmdll_sel_ctrl;

  localparam int N_W = 4;
  localparam int M_W = 2;
  localparam int TO_W = 3;
  localparam int LOCK_N = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INJECT = 3'd1;
  localparam logic [2:0] ST_RECIRC = 3'd2;
  localparam logic [2:0] ST_ARM = 3'd3;
  localparam logic [2:0] ST_CAL = 3'd4;

  logic           clk;
  logic           rst;
  logic           en;
  logic           ring_edge;
  logic           ext_edge;
  logic [N_W-1:0] n_div;
  logic [M_W-1:0] m_div;
  logic [1:0]     sel;
  logic [N_W-1:0] n_cnt;
  logic [M_W-1:0] m_cnt;
  logic           err_early;
  logic           err_late;
  logic           locked;
  logic [2:0]     state;

  int errors = 0;
  int checks = 0;

  fmdll_sel_ctrl #(
    .N_W(N_W), .M_W(M_W), .TO_W(TO_W), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ring_edge(ring_edge), .ext_edge(ext_edge),
    .n_div(n_div), .m_div(m_div), .sel(sel), .n_cnt(n_cnt), .m_cnt(m_cnt),
    .err_early(err_early), .err_late(err_late), .locked(locked), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e);
    ring_edge = r;
    ext_edge = e;
    @(posedge clk);
    #1;
    ring_edge = 1'b0;
    ext_edge = 1'b0;
  endtask

  task automatic rings(input int k);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ring_edge = 1'b0; ext_edge = 1'b0;
    n_div = 4'd4; m_div = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 16'(sel), 16'h0);
    chk("rst_n_cnt", 16'(n_cnt), 16'h0);
    chk("rst_m_cnt", 16'(m_cnt), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_err_early", 16'(err_early), 16'h0);
    chk("rst_err_late", 16'(err_late), 16'h0);
    chk("rst_state", 16'(state), 16'(ST_IDLE));
    rst = 1'b0;

    // Normal sequencing, n_div=4, m_div=1
    en = 1'b1;
    cyc(1'b0, 1'b0);
    chk("idle_sel", 16'(sel), 16'h0);
    cyc(1'b0, 1'b1);
    chk("inj1_sel", 16'(sel), 16'h2);
    cyc(1'b0, 1'b0);
    chk("rec1_sel", 16'(sel), 16'h0);
    chk("rec1_state", 16'(state), 16'(ST_RECIRC));
    rings(3);
    chk("rec1_n_cnt3", 16'(n_cnt), 16'd3);
    rings(1);
    chk("arm1_state", 16'(state), 16'(ST_ARM));
    chk("arm1_n_cnt", 16'(n_cnt), 16'd0);
    cyc(1'b1, 1'b0);
    chk("arm1_ring_ign", 16'(n_cnt), 16'd0);
    cyc(1'b0, 1'b1);
    chk("ontime1_sel", 16'(sel), 16'h2);
    chk("ontime1_m_cnt", 16'(m_cnt), 16'd1);
    cyc(1'b0, 1'b0);
    chk("rec2_sel", 16'(sel), 16'h0);
    rings(4);
    cyc(1'b0, 1'b1);
    chk("cal_sel", 16'(sel), 16'h1);
    chk("cal_m_cnt", 16'(m_cnt), 16'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("cal_hold_sel", 16'(sel), 16'h1);
    chk("cal_hold_state", 16'(state), 16'(ST_CAL));
    cyc(1'b0, 1'b1);
    chk("cal_exit_sel", 16'(sel), 16'h2);
    cyc(1'b0, 1'b0);

    // Early reference edge after 2 of 4 loop edges
    rings(2);
    chk("early_pre_n_cnt", 16'(n_cnt), 16'd2);
    cyc(1'b0, 1'b1);
    chk("early_err", 16'(err_early), 16'h1);
    chk("early_sel", 16'(sel), 16'h2);
    chk("early_n_cnt", 16'(n_cnt), 16'd0);
    chk("early_m_cnt", 16'(m_cnt), 16'd0);
    cyc(1'b0, 1'b0);
    chk("early_pulse_end", 16'(err_early), 16'h0);
    chk("early_rec_sel", 16'(sel), 16'h0);

    // Coincident terminal ring + ext; new divisors only apply at the next INJECT
    n_div = 4'd3; m_div = 2'd2;
    rings(3);
    chk("old_n_sh_n_cnt", 16'(n_cnt), 16'd3);
    cyc(1'b1, 1'b1);
    chk("coin1_err", 16'(err_early), 16'h0);
    chk("coin1_sel", 16'(sel), 16'h2);
    chk("coin1_m_cnt", 16'(m_cnt), 16'd1);
    cyc(1'b0, 1'b0);
    rings(2);
    cyc(1'b1, 1'b1);
    chk("coin2_err", 16'(err_early), 16'h0);
    chk("coin2_sel", 16'(sel), 16'h2);
    chk("coin2_m_cnt", 16'(m_cnt), 16'd2);
    chk("lock2_locked", 16'(locked), 16'h0);
    cyc(1'b0, 1'b0);

    // Lock build-up: 3rd and 4th on-time edges
    rings(3);
    chk("arm3_state", 16'(state), 16'(ST_ARM));
    cyc(1'b0, 1'b1);
    chk("lock3_sel", 16'(sel), 16'h1);
    chk("lock3_locked", 16'(locked), 16'h0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    rings(3);
    cyc(1'b0, 1'b1);
    chk("lock4_locked", 16'(locked), 16'h1);
    chk("lock4_m_cnt", 16'(m_cnt), 16'd1);
    cyc(1'b0, 1'b0);
    rings(1);
    chk("pre_dis_n_cnt", 16'(n_cnt), 16'd1);
    en = 1'b0;
    cyc(1'b0, 1'b0);
    chk("dis_sel", 16'(sel), 16'h0);
    chk("dis_locked", 16'(locked), 16'h0);
    chk("dis_n_cnt", 16'(n_cnt), 16'd0);
    chk("dis_m_cnt", 16'(m_cnt), 16'd0);
    chk("dis_state", 16'(state), 16'(ST_IDLE));
    cyc(1'b0, 1'b1);
    chk("dis_ext_sel", 16'(sel), 16'h0);
    chk("dis_ext_err", 16'(err_early), 16'h0);

    // ARM timeout with TO_W=3: err_late after 7 ARM cycles
    en = 1'b1;
    cyc(1'b0, 1'b1);
    chk("to_inj_sel", 16'(sel), 16'h2);
    cyc(1'b0, 1'b0);
    rings(3);
    chk("to_arm_state", 16'(state), 16'(ST_ARM));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
    chk("to_6_err", 16'(err_late), 16'h0);
    chk("to_6_state", 16'(state), 16'(ST_ARM));
    cyc(1'b0, 1'b0);
    chk("to_7_err", 16'(err_late), 16'h1);
    chk("to_7_state", 16'(state), 16'(ST_IDLE));
    chk("to_7_sel", 16'(sel), 16'h0);
    chk("to_7_locked", 16'(locked), 16'h0);
    cyc(1'b0, 1'b0);
    chk("to_pulse_end", 16'(err_late), 16'h0);

    // n_div=0 behaves as 1
    n_div = 4'd0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("n0_rec_state", 16'(state), 16'(ST_RECIRC));
    cyc(1'b1, 1'b0);
    chk("n0_arm_state", 16'(state), 16'(ST_ARM));
    chk("n0_n_cnt", 16'(n_cnt), 16'd0);
    cyc(1'b0, 1'b1);
    chk("n0_ontime_sel", 16'(sel), 16'h2);
    chk("n0_ontime_err", 16'(err_early), 16'h0);
    chk("n0_m_cnt", 16'(m_cnt), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
